// File: rtl/wasm_operand_stack_frames_pkg.sv
// Shared types and constants for the WASM operand stack with call frames.
package wasm_operand_stack_frames_pkg;

  localparam int DEF_W       = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_POP_MAX = 3;

  localparam int FRAME_PW = 16;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_FRM  = 2;
  localparam int ERR_DROP = 3;
  localparam int ERR_N    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_COPY = 2'd2
  } st_e;

  typedef struct packed {
    logic [FRAME_PW-1:0] base;
    logic [FRAME_PW-1:0] floor;
  } frame_t;

endpackage

// File: rtl/wasm_operand_stack_frames_if.sv
// Command/data bundle between the control unit and the operand stack.
interface wasm_operand_stack_frames_if
  import wasm_operand_stack_frames_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int POP_MAX     = DEF_POP_MAX,
  parameter int FRAME_DEPTH = 16,
  parameter int RET_MAX     = 4,
  parameter int LOC_MAX     = 64
);
  logic                              i_push_en;
  logic [W-1:0]                      i_push_data;
  logic [$clog2(POP_MAX+1)-1:0]      i_pop_num;
  logic [POP_MAX*W-1:0]              o_pop_win;
  logic                              i_call;
  logic [$clog2(LOC_MAX+1)-1:0]      i_call_para_num;
  logic [$clog2(LOC_MAX+1)-1:0]      i_call_loc_num;
  logic                              i_return;
  logic [$clog2(RET_MAX+1)-1:0]      i_ret_num;
  logic                              i_local_set;
  logic [$clog2(LOC_MAX)-1:0]        i_local_idx;
  logic [W-1:0]                      i_local_wdata;
  logic [W-1:0]                      o_local_rdata;
  logic                              o_ready;
  logic [$clog2(DEPTH):0]            o_top_ptr;
  logic [$clog2(FRAME_DEPTH):0]      o_frame_cnt;
  logic                              o_overflow;
  logic                              o_underflow;
  logic                              o_frame_err;
  logic                              o_cmd_drop;

  modport master (
    output i_push_en, i_push_data, i_pop_num,
    output i_call, i_call_para_num, i_call_loc_num,
    output i_return, i_ret_num,
    output i_local_set, i_local_idx, i_local_wdata,
    input  o_pop_win, o_local_rdata, o_ready,
    input  o_top_ptr, o_frame_cnt,
    input  o_overflow, o_underflow, o_frame_err, o_cmd_drop
  );

  modport slave (
    input  i_push_en, i_push_data, i_pop_num,
    input  i_call, i_call_para_num, i_call_loc_num,
    input  i_return, i_ret_num,
    input  i_local_set, i_local_idx, i_local_wdata,
    output o_pop_win, o_local_rdata, o_ready,
    output o_top_ptr, o_frame_cnt,
    output o_overflow, o_underflow, o_frame_err, o_cmd_drop
  );

endinterface

// File: rtl/wasm_frame_lifo.sv
// LIFO of saved {base, floor} frame records.
module wasm_frame_lifo
  import wasm_operand_stack_frames_pkg::*;
#(
  parameter int FRAME_DEPTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  frame_t                       i_data,
  output frame_t                       o_top,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(FRAME_DEPTH):0] o_cnt
);
  localparam int AW = $clog2(FRAME_DEPTH);
  localparam int CW = AW + 1;

  frame_t        r_mem [FRAME_DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_dec;

  assign w_dec   = r_cnt - CW'(1);
  assign o_full  = (r_cnt == CW'(FRAME_DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_top   = o_empty ? '0 : r_mem[w_dec[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= w_dec;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_push && !o_full) begin
      r_mem[r_cnt[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/wasm_operand_stack_frames.sv
// WASM operand stack with call frames, zero-filled locals and multi-value return.
// Define WASM_OPSTACK_TRAP_EN to freeze on the first error until reset.
module wasm_operand_stack_frames
  import wasm_operand_stack_frames_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int POP_MAX     = DEF_POP_MAX,
  parameter int FRAME_DEPTH = 16,
  parameter int RET_MAX     = 4,
  parameter int LOC_MAX     = 64
) (
  input logic i_clk,
  input logic i_rst,
  wasm_operand_stack_frames_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int LNW = $clog2(LOC_MAX + 1);
  localparam int XW  = PW + LNW + 1;
  localparam int FCW = $clog2(FRAME_DEPTH) + 1;

  logic [W-1:0]     r_mem [DEPTH];
  st_e              r_state, w_state_nxt;
  logic [PW-1:0]    r_top, r_base, r_floor;
  logic [PW-1:0]    w_top_nxt, w_base_nxt, w_floor_nxt;
  logic [AW-1:0]    r_src, r_dst, w_src_nxt, w_dst_nxt;
  logic [XW-1:0]    r_cnt, w_cnt_nxt;
  logic [ERR_N-1:0] r_err, w_err_nxt;

  logic          w_frz, w_data, w_cmd;
  logic          w_under, w_over, w_lok;
  logic          w_ret_bad, w_call_bad, w_call_ovf;
  logic [PW-1:0] w_avail, w_lsize;
  logic [XW-1:0] w_newtop;
  logic [AW-1:0] w_paddr, w_laddr;
  logic          w_we0, w_we1;
  logic [AW-1:0] w_wa0, w_wa1;
  logic [W-1:0]  w_wd0, w_wd1;
  logic          w_lf_push, w_lf_pop, w_lf_full, w_lf_empty;
  frame_t        w_lf_top, w_lf_din;
  logic [FCW-1:0] w_lf_cnt;
  logic [POP_MAX*W-1:0] w_pop_win;

`ifdef WASM_OPSTACK_TRAP_EN
  assign w_frz = |r_err;
`else
  assign w_frz = 1'b0;
`endif

  assign w_avail  = r_top - r_floor;
  assign w_lsize  = r_floor - r_base;
  assign w_data   = bus.i_push_en | (bus.i_pop_num != '0) | bus.i_local_set;
  assign w_cmd    = bus.i_call | bus.i_return | w_data;
  assign w_under  = XW'(bus.i_pop_num) > XW'(w_avail);
  assign w_newtop = XW'(r_top) - XW'(bus.i_pop_num) + XW'(bus.i_push_en);
  assign w_over   = w_newtop > XW'(DEPTH);
  assign w_paddr  = AW'(r_top - PW'(bus.i_pop_num));
  assign w_lok    = XW'(bus.i_local_idx) < XW'(w_lsize);
  assign w_laddr  = AW'(r_base + PW'(bus.i_local_idx));

  assign w_ret_bad = (XW'(bus.i_ret_num) > XW'(w_avail)) ||
                     (XW'(bus.i_ret_num) > XW'(RET_MAX));
  assign w_call_bad = (XW'(bus.i_call_para_num) > XW'(w_avail)) ||
                      (XW'(bus.i_call_para_num) + XW'(bus.i_call_loc_num) >
                       XW'(LOC_MAX));
  assign w_call_ovf = XW'(r_top) + XW'(bus.i_call_loc_num) > XW'(DEPTH);

  assign w_lf_din = '{base: FRAME_PW'(r_base), floor: FRAME_PW'(r_floor)};

  wasm_frame_lifo #(.FRAME_DEPTH(FRAME_DEPTH)) u_lifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_lf_push),
    .i_pop   (w_lf_pop),
    .i_data  (w_lf_din),
    .o_top   (w_lf_top),
    .o_full  (w_lf_full),
    .o_empty (w_lf_empty),
    .o_cnt   (w_lf_cnt)
  );

  always_comb begin
    w_pop_win = '0;
    for (int k = 0; k < POP_MAX; k++) begin
      if (XW'(k) < XW'(w_avail)) begin
        w_pop_win[k*W +: W] = r_mem[AW'(r_top - PW'(k + 1))];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_top_nxt   = r_top;
    w_base_nxt  = r_base;
    w_floor_nxt = r_floor;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_lf_push   = 1'b0;
    w_lf_pop    = 1'b0;
    w_we0       = 1'b0;
    w_wa0       = '0;
    w_wd0       = '0;
    w_we1       = 1'b0;
    w_wa1       = '0;
    w_wd1       = '0;
    if (!w_frz) begin
      unique case (r_state)
        ST_IDLE: begin
          priority case (1'b1)
            bus.i_return: begin
              if (bus.i_call | w_data) w_err_nxt[ERR_DROP] = 1'b1;
              if (w_lf_empty || w_ret_bad) begin
                w_err_nxt[ERR_FRM] = 1'b1;
              end else if (bus.i_ret_num == '0) begin
                w_top_nxt   = r_base;
                w_base_nxt  = PW'(w_lf_top.base);
                w_floor_nxt = PW'(w_lf_top.floor);
                w_lf_pop    = 1'b1;
              end else begin
                w_state_nxt = ST_COPY;
                w_cnt_nxt   = XW'(bus.i_ret_num);
                w_src_nxt   = AW'(r_top - PW'(bus.i_ret_num));
                w_dst_nxt   = AW'(r_base);
              end
            end
            bus.i_call: begin
              if (w_data) w_err_nxt[ERR_DROP] = 1'b1;
              if (w_lf_full || w_call_bad) begin
                w_err_nxt[ERR_FRM] = 1'b1;
              end else if (w_call_ovf) begin
                w_err_nxt[ERR_OVF] = 1'b1;
              end else begin
                w_lf_push   = 1'b1;
                w_base_nxt  = r_top - PW'(bus.i_call_para_num);
                w_floor_nxt = r_top + PW'(bus.i_call_loc_num);
                if (bus.i_call_loc_num != '0) begin
                  w_state_nxt = ST_ZERO;
                  w_cnt_nxt   = XW'(bus.i_call_loc_num);
                end
              end
            end
            w_data: begin
              if (w_under) begin
                w_err_nxt[ERR_UNF] = 1'b1;
              end else if (w_over) begin
                w_err_nxt[ERR_OVF] = 1'b1;
              end else begin
                w_top_nxt = PW'(w_newtop);
                w_we0     = bus.i_push_en;
                w_wa0     = w_paddr;
                w_wd0     = bus.i_push_data;
                if (bus.i_local_set) begin
                  if (w_lok) begin
                    w_we1 = 1'b1;
                    w_wa1 = w_laddr;
                    w_wd1 = bus.i_local_wdata;
                  end else begin
                    w_err_nxt[ERR_FRM] = 1'b1;
                  end
                end
              end
            end
            default: ;
          endcase
        end
        ST_ZERO: begin
          if (w_cmd) w_err_nxt[ERR_DROP] = 1'b1;
          w_we0     = 1'b1;
          w_wa0     = AW'(r_top);
          w_top_nxt = r_top + PW'(1);
          w_cnt_nxt = r_cnt - XW'(1);
          if (r_cnt == XW'(1)) w_state_nxt = ST_IDLE;
        end
        ST_COPY: begin
          if (w_cmd) w_err_nxt[ERR_DROP] = 1'b1;
          w_we0     = 1'b1;
          w_wa0     = r_dst;
          w_wd0     = r_mem[r_src];
          w_src_nxt = r_src + AW'(1);
          w_dst_nxt = r_dst + AW'(1);
          w_cnt_nxt = r_cnt - XW'(1);
          // Last result lands at r_dst, so the caller's top is just above it.
          if (r_cnt == XW'(1)) begin
            w_state_nxt = ST_IDLE;
            w_top_nxt   = PW'(r_dst) + PW'(1);
            w_base_nxt  = PW'(w_lf_top.base);
            w_floor_nxt = PW'(w_lf_top.floor);
            w_lf_pop    = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_top   <= '0;
      r_base  <= '0;
      r_floor <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_top   <= w_top_nxt;
      r_base  <= w_base_nxt;
      r_floor <= w_floor_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Port 0 is written second so a push beats a local write to the same slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_we1) r_mem[w_wa1] <= w_wd1;
      if (w_we0) r_mem[w_wa0] <= w_wd0;
    end
  end

  assign bus.o_pop_win     = w_pop_win;
  assign bus.o_local_rdata = w_lok ? r_mem[w_laddr] : '0;
  assign bus.o_ready       = (r_state == ST_IDLE) && !w_frz;
  assign bus.o_top_ptr     = r_top;
  assign bus.o_frame_cnt   = w_lf_cnt;
  assign bus.o_overflow    = r_err[ERR_OVF];
  assign bus.o_underflow   = r_err[ERR_UNF];
  assign bus.o_frame_err   = r_err[ERR_FRM];
  assign bus.o_cmd_drop    = r_err[ERR_DROP];

endmodule

// File: tb/tb_wasm_operand_stack_frames.sv
// Directed bench for wasm_operand_stack_frames (DEPTH=8, FRAME_DEPTH=2).
module tb_wasm_operand_stack_frames;
  localparam int W  = 32;
  localparam int DP = 8;
  localparam int PM = 3;
  localparam int FD = 2;
  localparam int RM = 4;
  localparam int LM = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  wasm_operand_stack_frames_if #(
    .W(W), .DEPTH(DP), .POP_MAX(PM),
    .FRAME_DEPTH(FD), .RET_MAX(RM), .LOC_MAX(LM)
  ) bus ();

  wasm_operand_stack_frames #(
    .W(W), .DEPTH(DP), .POP_MAX(PM),
    .FRAME_DEPTH(FD), .RET_MAX(RM), .LOC_MAX(LM)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        push;
    logic [31:0] data;
    logic [1:0]  pop;
    logic [3:0]  top;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vt [9];

  task automatic clr();
    bus.i_push_en       = 1'b0;
    bus.i_push_data     = '0;
    bus.i_pop_num       = '0;
    bus.i_call          = 1'b0;
    bus.i_call_para_num = '0;
    bus.i_call_loc_num  = '0;
    bus.i_return        = 1'b0;
    bus.i_ret_num       = '0;
    bus.i_local_set     = 1'b0;
    bus.i_local_idx     = '0;
    bus.i_local_wdata   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.o_overflow, bus.o_underflow, bus.o_frame_err, bus.o_cmd_drop};
  endfunction

  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    bus.i_push_en   = 1'b1;
    bus.i_push_data = d;
    step();
    bus.i_push_en   = 1'b0;
  endtask

  task automatic call(input int p, input int l);
    bus.i_call          = 1'b1;
    bus.i_call_para_num = 7'(p);
    bus.i_call_loc_num  = 7'(l);
    step();
    clr();
  endtask

  task automatic ret(input int r);
    bus.i_return  = 1'b1;
    bus.i_ret_num = 3'(r);
    step();
    clr();
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!bus.o_ready && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic rd_local(input int idx, input logic [31:0] exp);
    bus.i_local_idx = 6'(idx);
    #1;
    chk($sformatf("local%0d", idx), bus.o_local_rdata, exp);
  endtask

  initial begin
    int n;
    vt[0] = '{1'b1, 32'd5,  2'd0, 4'd1, 32'd5,  32'd0,  32'd0};
    vt[1] = '{1'b1, 32'd7,  2'd0, 4'd2, 32'd7,  32'd5,  32'd0};
    vt[2] = '{1'b1, 32'd12, 2'd2, 4'd1, 32'd12, 32'd0,  32'd0};
    vt[3] = '{1'b1, 32'd3,  2'd0, 4'd2, 32'd3,  32'd12, 32'd0};
    vt[4] = '{1'b1, 32'd4,  2'd0, 4'd3, 32'd4,  32'd3,  32'd12};
    vt[5] = '{1'b1, 32'd9,  2'd1, 4'd3, 32'd9,  32'd3,  32'd12};
    vt[6] = '{1'b0, 32'd0,  2'd3, 4'd0, 32'd0,  32'd0,  32'd0};
    vt[7] = '{1'b1, 32'd6,  2'd0, 4'd1, 32'd6,  32'd0,  32'd0};
    vt[8] = '{1'b0, 32'd0,  2'd0, 4'd1, 32'd6,  32'd0,  32'd0};

    do_reset();
    chk("rst_top", bus.o_top_ptr, 0);
    chk("rst_rdy", bus.o_ready, 1);
    chk("rst_fc", bus.o_frame_cnt, 0);
    chk("rst_flags", flags(), 0);

    for (int i = 0; i < 9; i++) begin
      bus.i_push_en   = vt[i].push;
      bus.i_push_data = vt[i].data;
      bus.i_pop_num   = vt[i].pop;
      step();
      clr();
      chk($sformatf("v%0d_top", i), bus.o_top_ptr, vt[i].top);
      chk($sformatf("v%0d_win", i), bus.o_pop_win,
          {vt[i].w2, vt[i].w1, vt[i].w0});
      chk($sformatf("v%0d_flags", i), flags(), 0);
    end

    // call para=2 loc=3, locals, push, multi-value return
    do_reset();
    push(5);
    push(7);
    call(2, 3);
    chk("call_fc", bus.o_frame_cnt, 1);
    wait_rdy(n);
    chk("zero_cycles", n, 3);
    chk("call_top", bus.o_top_ptr, 5);
    rd_local(0, 5);
    rd_local(1, 7);
    rd_local(2, 0);
    rd_local(4, 0);
    rd_local(5, 0);
    bus.i_local_set   = 1'b1;
    bus.i_local_idx   = 6'd2;
    bus.i_local_wdata = 32'h55;
    step();
    clr();
    rd_local(2, 32'h55);
    push(9);
    push(8);
    chk("frm_top", bus.o_top_ptr, 7);
    chk("frm_win", bus.o_pop_win, {32'd0, 32'd9, 32'd8});
    ret(2);
    wait_rdy(n);
    chk("copy_cycles", n, 2);
    chk("ret_top", bus.o_top_ptr, 2);
    chk("ret_fc", bus.o_frame_cnt, 0);
    chk("ret_win", bus.o_pop_win, {32'd0, 32'd9, 32'd8});
    chk("ret_flags", flags(), 0);

    // empty frame with zero-length return
    call(0, 0);
    chk("c0_rdy", bus.o_ready, 1);
    chk("c0_fc", bus.o_frame_cnt, 1);
    rd_local(0, 0);
    ret(0);
    chk("r0_fc", bus.o_frame_cnt, 0);
    chk("r0_top", bus.o_top_ptr, 2);
    chk("r0_flags", flags(), 0);

    // underflow and return without frame
    do_reset();
    bus.i_pop_num = 2'd1;
    step();
    clr();
    chk("unf_flags", flags(), 4'b0100);
    chk("unf_top", bus.o_top_ptr, 0);
    do_reset();
    ret(0);
    chk("rnf_flags", flags(), 4'b0010);

    // overflow at DEPTH
    do_reset();
    for (int i = 1; i <= 9; i++) push(32'(i));
    chk("ovf_flags", flags(), 4'b1000);
    chk("ovf_top", bus.o_top_ptr, 8);
    chk("ovf_lane0", bus.o_pop_win[31:0], 8);
`ifdef WASM_OPSTACK_TRAP_EN
    bus.i_pop_num = 2'd1;
    step();
    clr();
    chk("trap_rdy", bus.o_ready, 0);
    chk("trap_top", bus.o_top_ptr, 8);
    do_reset();
    chk("trap_clr", bus.o_ready, 1);
`else
    chk("ovf_rdy", bus.o_ready, 1);
    bus.i_pop_num = 2'd1;
    step();
    clr();
    chk("ovf_pop", bus.o_top_ptr, 7);
`endif

    // push dropped during ZERO, then reset mid-COPY
    do_reset();
    push(1);
    call(1, 2);
    push(99);
    wait_rdy(n);
    chk("drop_wait", n, 1);
    chk("drop_top", bus.o_top_ptr, 3);
    chk("drop_flags", flags(), 4'b0001);
    rd_local(0, 1);
    rd_local(1, 0);
    clr();
    push(4);
    push(5);
    ret(2);
    chk("copy_busy", bus.o_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_top", bus.o_top_ptr, 0);
    chk("mrst_rdy", bus.o_ready, 1);
    chk("mrst_flags", flags(), 0);
    chk("mrst_fc", bus.o_frame_cnt, 0);

    // frame LIFO full
    do_reset();
    call(0, 0);
    call(0, 0);
    call(0, 0);
    chk("full_fc", bus.o_frame_cnt, 2);
    chk("full_flags", flags(), 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
